// File: rtl/vector_scale_serial.sv
// vector_scale_serial: scalar-times-vector float product, one element per clock through a shared multiplier.
// Optional VEC_SCALE_ZERO_SKIP_EN: a +/-0 scalar bypasses RUN and writes signed zeros straight into DONE.

// FloatingMultiplication: single-precision multiply, round-to-nearest-even; denormal inputs and
// results flush to signed zero, overflow gives signed Inf, every NaN result is 0x7FC00000.
module FloatingMultiplication (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] p_o
);
   logic              s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st, inc;
   logic [47:0]       prod;
   logic [22:0]       man;
   logic [23:0]       frac_r;
   logic signed [9:0] exp_n, exp_r;
   always_comb begin
      s      = a_i[31] ^ b_i[31];
      a_zero = a_i[30:23] == 8'd0;
      b_zero = b_i[30:23] == 8'd0;
      a_inf  = a_i[30:23] == 8'hFF && a_i[22:0] == 23'd0;
      b_inf  = b_i[30:23] == 8'hFF && b_i[22:0] == 23'd0;
      a_nan  = a_i[30:23] == 8'hFF && a_i[22:0] != 23'd0;
      b_nan  = b_i[30:23] == 8'hFF && b_i[22:0] != 23'd0;
      prod   = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};
      // product of two [1,2) mantissas lies in [1,4): bit 47 selects the one-place normalise
      man    = prod[47] ? prod[46:24] : prod[45:23];
      g      = prod[47] ? prod[23] : prod[22];
      st     = prod[47] ? |prod[22:0] : |prod[21:0];
      inc    = g & (st | man[0]);
      frac_r = {1'b0, man} + {23'd0, inc};
      exp_n  = $signed({2'b0, a_i[30:23]}) + $signed({2'b0, b_i[30:23]}) - 10'sd127
               + $signed({9'd0, prod[47]});
      exp_r  = exp_n + $signed({9'd0, frac_r[23]});
      p_o    = (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) ? 32'h7FC00000
             : (a_inf | b_inf | (exp_r > 10'sd254))                  ? {s, 8'hFF, 23'd0}
             : (a_zero | b_zero | (exp_r < 10'sd1))                  ? {s, 31'd0}
             :                                                         {s, exp_r[7:0], frac_r[22:0]};
   end
endmodule

module vector_scale_serial #(
   parameter int VLEN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         S,
   input  logic [32*VLEN-1:0]  V,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*VLEN-1:0]  result
);
   localparam int IW = VLEN > 1 ? $clog2(VLEN) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [31:0]        s_q, s_d, v_el, prod;
   logic [32*VLEN-1:0] v_q, v_d, res_q, res_d;
   logic               last;
   FloatingMultiplication u_fmul (
      .a_i (s_q),
      .b_i (v_el),
      .p_o (prod)
   );
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      s_d     = s_q;
      v_d     = v_q;
      res_d   = res_q;
      v_el    = 32'd0;
      last    = idx_q == IW'(VLEN - 1);
      for (int i = 0; i < VLEN; i++)
         if (idx_q == IW'(i)) v_el = v_q[32*i +: 32];
      unique case (state_q)
         IDLE: if (in_valid) begin
            s_d     = S;
            v_d     = V;
            idx_d   = '0;
            state_d = RUN;
`ifdef VEC_SCALE_ZERO_SKIP_EN
            if (S[30:0] == 31'd0) begin
               state_d = DONE;
               for (int i = 0; i < VLEN; i++) res_d[32*i +: 32] = {S[31] ^ V[32*i+31], 31'd0};
            end
`endif
         end
         RUN: begin
            for (int i = 0; i < VLEN; i++)
               if (idx_q == IW'(i)) res_d[32*i +: 32] = prod;
            state_d = last ? DONE : RUN;
            idx_d   = last ? idx_q : idx_q + 1'b1;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         s_q     <= '0;
         v_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
         v_q     <= v_d;
         res_q   <= res_d;
      end
   end
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign result    = res_q;
endmodule

// File: tb/tb_vector_scale_serial.sv
// tb_vector_scale_serial: directed vector table, hand-written handshake/reset sequences and
// random operands checked against a real-arithmetic reference for vector_scale_serial.
module tb_vector_scale_serial;
   localparam int VLEN = 4;
`ifdef VEC_SCALE_ZERO_SKIP_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = VLEN + 1;
`endif
   typedef struct {
      string        name;
      logic [31:0]  s;
      logic [127:0] v;
      logic [127:0] e;
      int           lat;
   } vec_t;
   logic               clk = 1'b0, rst = 1'b1;
   logic               in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
   logic [31:0]        S = '0;
   logic [32*VLEN-1:0] V = '0, result;
   logic               u1_in_valid = 1'b0, u1_out_ready = 1'b0, u1_in_ready, u1_out_valid;
   logic [31:0]        u1_S = '0, u1_V = '0, u1_result;
   int                 n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   vector_scale_serial #(.VLEN(VLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S(S), .V(V),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );
   vector_scale_serial #(.VLEN(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready), .S(u1_S), .V(u1_V),
      .out_valid(u1_out_valid), .out_ready(u1_out_ready), .result(u1_result)
   );
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   function automatic real to_real(input logic [31:0] f);
      logic [10:0] e;
      e = {3'b0, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction
   // exact double product, then round-to-nearest-even down to single precision
   function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] d;
      logic [23:0] m;
      logic [28:0] rb;
      int          e;
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
      d  = $realtobits(to_real(a) * to_real(b));
      e  = int'(d[62:52]) - 896;
      m  = {1'b0, d[51:29]};
      rb = d[28:0];
      if (rb > 29'h10000000 || (rb == 29'h10000000 && m[0])) m = m + 24'd1;
      if (m[23]) begin
         e++;
         m = '0;
      end
      return {d[63], e[7:0], m[22:0]};
   endfunction
   function automatic logic [31:0] rnd_f();
      return {1'($urandom), 8'($urandom_range(189, 64)), 23'($urandom)};
   endfunction
   task automatic do_op(input logic [31:0] s, input logic [127:0] v, input bit hold,
                        output logic [127:0] r, output int lat);
      int n;
      @(negedge clk);
      S = s;
      V = v;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", in_ready, 1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      S = ~s;
      V = ~v;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      r = result;
      if (!hold) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vec_t         tbl[7];
      logic [127:0] r, vr, held;
      logic [31:0]  rs;
      int           lat;
      tbl[0] = '{"plan", 32'h40000000, {32'h3F000000, 32'hBF800000, 32'h3FC00000, 32'h40000000},
                 {32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40800000}, VLEN + 1};
      tbl[1] = '{"neg_one", 32'hBF800000, {4{32'h3F800000}}, {4{32'hBF800000}}, VLEN + 1};
      tbl[2] = '{"neg_zero", 32'h80000000, {32'h00000000, 32'h40000000, 32'hBF800000, 32'h3F800000},
                 {32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000}, ZLAT};
      tbl[3] = '{"round", 32'h3F800001, {32'h3F800000, 32'hBF800001, 32'h3F800001, 32'h3F800003},
                 {32'h3F800001, 32'hBF800002, 32'h3F800002, 32'h3F800004}, VLEN + 1};
      tbl[4] = '{"tie_down", 32'h3F800800, {32'h3F800800, 32'h3F800000, 32'hBF800800, 32'h3F800001},
                 {32'h3F801000, 32'h3F800800, 32'hBF801000, 32'h3F800801}, VLEN + 1};
      tbl[5] = '{"tie_up", 32'h3FC00000, {32'h3FC00000, 32'h3F800000, 32'h40000000, 32'h3F800001},
                 {32'h40100000, 32'h3FC00000, 32'h40400000, 32'h3FC00002}, VLEN + 1};
      tbl[6] = '{"ovf", 32'h7F000000, {32'h3F800000, 32'h40000000, 32'h00800000, 32'h00000000},
                 {32'h7F000000, 32'h7F800000, 32'h40000000, 32'h00000000}, VLEN + 1};
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_result", result, 0);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         do_op(tbl[k].s, tbl[k].v, 1'b0, r, lat);
         check({tbl[k].name, "_result"}, r, tbl[k].e);
         check({tbl[k].name, "_latency"}, lat, tbl[k].lat);
      end
      for (int k = 0; k < 24; k++) begin
         rs = rnd_f();
         for (int i = 0; i < VLEN; i++) vr[32*i +: 32] = rnd_f();
         do_op(rs, vr, 1'b0, r, lat);
         for (int i = 0; i < VLEN; i++) held[32*i +: 32] = mul_ref(rs, vr[32*i +: 32]);
         check("random_result", r, held);
         check("random_latency", lat, VLEN + 1);
      end
      // backpressure: result held, new requests ignored
      do_op(tbl[0].s, tbl[0].v, 1'b1, r, lat);
      check("bp_result", r, tbl[0].e);
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'($urandom);
         S = $urandom;
         V = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_hold", result, tbl[0].e);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      // back-to-back with in_valid and out_ready held high
      S = tbl[0].s;
      V = tbl[0].v;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      S = 32'hBF800000;
      V = {4{32'h3F800000}};
      repeat (4) @(negedge clk);
      check("b2b_first_valid", out_valid, 1);
      check("b2b_first_result", result, tbl[0].e);
      @(negedge clk);
      check("b2b_idle_ready", in_ready, 1);
      check("b2b_idle_valid", out_valid, 0);
      @(negedge clk);
      check("b2b_second_accept", in_ready, 0);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("b2b_second_valid", out_valid, 1);
      check("b2b_second_result", result, {4{32'hBF800000}});
      @(negedge clk);
      out_ready = 1'b0;
      // reset while idx == 2
      S = tbl[0].s;
      V = tbl[0].v;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_result", result, 0);
      @(negedge clk);
      rst = 1'b0;
      do_op(tbl[0].s, tbl[0].v, 1'b0, r, lat);
      check("post_rst_result", r, tbl[0].e);
      check("post_rst_latency", lat, VLEN + 1);
      // single-element instance
      @(negedge clk);
      u1_S = 32'h3FC00000;
      u1_V = 32'h40000000;
      u1_in_valid = 1'b1;
      check("v1_ready", u1_in_ready, 1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      u1_in_valid = 1'b0;
      while (!u1_out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("v1_latency", lat, 2);
      check("v1_result", u1_result, 32'h40400000);
      u1_out_ready = 1'b1;
      @(negedge clk);
      u1_out_ready = 1'b0;
      check("v1_release", u1_out_valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
